// File: rtl/tile_line_fetcher_pkg.sv
// Shared types and constants for the tile line fetcher: FSM states,
// character-entry field positions, tile geometry and the words-per-row helper.
package tile_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    PAT  = 2'd2,
    PUSH = 2'd3
  } fetch_state_t;

  localparam int TILE_W = 8;
  localparam int TILE_H = 8;

  localparam int ENT_ID_LSB   = 0;
  localparam int ENT_ID_W     = 9;
  localparam int ENT_PAL_LSB  = 9;
  localparam int ENT_PAL_W    = 4;
  localparam int ENT_FLIP_BIT = 13;

  // 1bpp still costs one full word per row; only its low byte is used.
  function automatic int wpr(input int bpp);
    return (bpp < 2) ? 1 : bpp / 2;
  endfunction

endpackage

// File: rtl/tile_line_fetcher_if.sv
// Handshake and SRAM bus bundle of the tile line fetcher; master is the fetcher side.
interface tile_line_fetcher_if;
  logic        line_start;
  logic [9:0]  line_y;
  logic        busy;
  logic        line_done;
  logic [7:0]  px_data;
  logic        px_valid;
  logic        px_ready;
  logic [17:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_ce;
  logic        ram_oe;
  logic        ram_we;
  logic        ram_lb;
  logic        ram_hb;

  modport master (
    input  line_start, line_y, px_ready, ram_din,
    output busy, line_done, px_data, px_valid,
           ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );

  modport slave (
    output line_start, line_y, px_ready, ram_din,
    input  busy, line_done, px_data, px_valid,
           ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );
endinterface

// File: rtl/tile_line_fetcher_row_shifter.sv
// tile_row_shifter: holds one tile row of pattern words and returns the
// palette index of pixel k, optionally mirrored.
module tile_row_shifter
  import tile_fetch_pkg::*;
#(
  parameter int BPP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [1:0]  i_word_sel,
  input  logic [15:0] i_word,
  input  logic        i_flip,
  input  logic [2:0]  i_k,
  output logic [3:0]  o_index
);
  localparam int ROW_BITS = TILE_W * BPP;
  localparam int WPR      = wpr(BPP);

  logic [ROW_BITS-1:0] r_row;
  logic [2:0]          w_pos;
  logic [4:0]          w_shamt;
  logic [ROW_BITS-1:0] w_shifted;

  generate
    if (BPP == 1) begin : g_byte
      // Row register load: the single word carries the row in its low byte.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_row <= '0;
        end else if (i_load && (i_word_sel == 2'd0)) begin
          r_row <= i_word[7:0];
        end
      end
    end else begin : g_words
      // Row register load: word 0 occupies the top bits so pixel 0 is the top field.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_row <= '0;
        end else if (i_load) begin
          for (int w = 0; w < WPR; w++) begin
            if (i_word_sel == 2'(w)) begin
              r_row[ROW_BITS-1-16*w -: 16] <= i_word;
            end
          end
        end
      end
    end
  endgenerate

  assign w_pos     = i_flip ? (3'd7 - i_k) : i_k;
  assign w_shamt   = 5'(BPP * (TILE_W - 1 - int'(w_pos)));
  assign w_shifted = r_row >> w_shamt;
  assign o_index   = 4'(w_shifted[BPP-1:0]);

endmodule

// File: rtl/tile_line_fetcher.sv
// Tile line fetcher: per line reads the character map, each tile's pattern row,
// and streams palette-tagged pixels. Optional mirroring via `HFLIP_EN.
module tile_line_fetcher
  import tile_fetch_pkg::*;
#(
  parameter int          TILES_PER_LINE = 40,
  parameter int          MAP_W          = 64,
  parameter logic [17:0] MAP_BASE       = 18'h00000,
  parameter logic [17:0] TILE_BASE      = 18'h10000,
  parameter int          BPP            = 4
) (
  input logic                 clk,
  input logic                 reset,
  tile_line_fetcher_if.master bus
);
  localparam int         WPR       = wpr(BPP);
  localparam logic [7:0] LAST_TILE = 8'(TILES_PER_LINE - 1);
  localparam logic [1:0] LAST_WORD = 2'(WPR - 1);

  fetch_state_t r_state;
  logic [9:0]   r_line_y;
  logic [7:0]   r_tile_n;
  logic [3:0]   r_pal;
  logic         r_flip;
  logic [1:0]   r_word;
  logic [2:0]   r_pix;
  logic [17:0]  r_pat_base;
  logic [17:0]  r_addr;
  logic         r_busy;
  logic         r_done;
  logic         r_valid;
  logic         r_ce;

  logic         w_accept;
  logic         w_ent_flip;
  logic [3:0]   w_index;
  logic [17:0]  w_pat_base;

  function automatic logic [17:0] map_addr(input logic [9:0] y, input logic [7:0] n);
    return MAP_BASE + 18'(y[9:3]) * 18'(MAP_W) + 18'(n);
  endfunction

  assign w_accept   = r_valid & bus.px_ready;
  assign w_pat_base = TILE_BASE
                    + 18'(bus.ram_din[ENT_ID_LSB +: ENT_ID_W]) * 18'(TILE_H * WPR)
                    + 18'(r_line_y[2:0]) * 18'(WPR);

`ifdef HFLIP_EN
  assign w_ent_flip = bus.ram_din[ENT_FLIP_BIT];
`else
  assign w_ent_flip = 1'b0;
`endif

  // Line sequencer: map entry, pattern words, then eight handshaked pixels per tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_line_y   <= 10'd0;
      r_tile_n   <= 8'd0;
      r_pal      <= 4'd0;
      r_flip     <= 1'b0;
      r_word     <= 2'd0;
      r_pix      <= 3'd0;
      r_pat_base <= 18'd0;
      r_addr     <= 18'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_ce       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.line_start) begin
            r_line_y <= bus.line_y;
            r_tile_n <= 8'd0;
            r_addr   <= map_addr(bus.line_y, 8'd0);
            r_ce     <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= CHAR;
          end
        end
        CHAR: begin
          r_pal      <= bus.ram_din[ENT_PAL_LSB +: ENT_PAL_W];
          r_flip     <= w_ent_flip;
          r_pat_base <= w_pat_base;
          r_addr     <= w_pat_base;
          r_word     <= 2'd0;
          r_state    <= PAT;
        end
        PAT: begin
          if (r_word == LAST_WORD) begin
            r_pix   <= 3'd0;
            r_valid <= 1'b1;
            r_state <= PUSH;
          end else begin
            r_word <= r_word + 2'd1;
            r_addr <= r_pat_base + 18'(r_word) + 18'd1;
          end
        end
        PUSH: begin
          if (w_accept) begin
            if (r_pix == 3'd7) begin
              r_valid <= 1'b0;
              if (r_tile_n < LAST_TILE) begin
                r_tile_n <= r_tile_n + 8'd1;
                r_addr   <= map_addr(r_line_y, r_tile_n + 8'd1);
                r_state  <= CHAR;
              end else begin
                r_ce    <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_addr  <= 18'd0;
                r_state <= IDLE;
              end
            end else begin
              r_pix <= r_pix + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tile_row_shifter #(.BPP(BPP)) u_row (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == PAT),
    .i_word_sel (r_word),
    .i_word     (bus.ram_din),
    .i_flip     (r_flip),
    .i_k        (r_pix),
    .o_index    (w_index)
  );

  assign bus.px_data   = r_valid ? {r_pal, w_index} : 8'h00;
  assign bus.px_valid  = r_valid;
  assign bus.busy      = r_busy;
  assign bus.line_done = r_done;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_ce    = r_ce;
  assign bus.ram_oe    = r_ce;
  assign bus.ram_we    = 1'b0;
  assign bus.ram_lb    = 1'b1;
  assign bus.ram_hb    = 1'b1;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Bench for tile_line_fetcher: a 4bpp/40-tile and a 1bpp/2-tile instance share one
// SRAM image; expected pixel streams come from a per-line model of the map/pattern rules.
module tb_tile_line_fetcher;
  localparam int T_A = 40;
  localparam int T_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fin = 1'b0;

  tile_line_fetcher_if bus_a ();
  tile_line_fetcher_if bus_b ();

  logic [15:0] mem [0:262143];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  int         pix_cnt [2];
  int         stalls [2];
  int         done_cnt [2];
  int         start_cyc [2];
  int         line_time [2];
  int         exp_cnt [2];
  int         duty [2];
  logic       prev_stall [2];
  logic [7:0] prev_data [2];
  logic [7:0] got [2][0:23];

  tile_line_fetcher #(.TILES_PER_LINE(T_A), .BPP(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  tile_line_fetcher #(.TILES_PER_LINE(T_B), .BPP(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_a.ram_din = mem[bus_a.ram_addr];
  assign bus_b.ram_din = mem[bus_b.ram_addr];

  task automatic chk(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Pixel k of tile n on line y, straight from the map/pattern addressing rules.
  function automatic logic [7:0] exp_px(input int bpp, input int y, input int n, input int p);
    logic [15:0] e;
    logic [31:0] bits;
    int id, row, q, base;
    e   = mem[18'((y / 8) * 64 + n)];
    id  = int'(e[8:0]);
    row = y % 8;
    q   = p;
`ifdef HFLIP_EN
    if (e[13]) q = 7 - p;
`endif
    if (bpp == 4) begin
      base = 32'h10000 + id * 16 + row * 2;
      bits = {mem[18'(base)], mem[18'(base + 1)]};
      return {e[12:9], 4'((bits >> (4 * (7 - q))) & 32'hF)};
    end
    base = 32'h10000 + id * 8 + row;
    bits = {16'h0000, mem[18'(base)]};
    return {e[12:9], 4'((bits >> (7 - q)) & 32'h1)};
  endfunction

  task automatic mon(input int d, input logic valid, input logic ready, input logic [7:0] data,
                     input logic done, input logic busy);
    logic [7:0] e;
    int qsz;
    qsz = (d == 0) ? q_a.size() : q_b.size();
    if (prev_stall[d]) begin
      chk($sformatf("stall_valid_%0d", d), int'(valid), 1);
      chk($sformatf("stall_hold_%0d", d), int'(data), int'(prev_data[d]));
    end
    if (valid && ready) begin
      if (qsz == 0) begin
        chk($sformatf("extra_pixel_%0d", d), 1, 0);
      end else begin
        if (d == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        chk($sformatf("pixel_%0d_%0d", d, pix_cnt[d]), int'(data), int'(e));
        if (pix_cnt[d] < 24) got[d][pix_cnt[d]] = data;
        pix_cnt[d]++;
      end
    end
    if (valid && !ready) stalls[d]++;
    prev_stall[d] = valid & ~ready;
    prev_data[d]  = data;
    if (done) begin
      line_time[d] = cyc - start_cyc[d] + 1;
      chk($sformatf("done_busy_low_%0d", d), int'(busy), 0);
      chk($sformatf("pixel_count_%0d", d), pix_cnt[d], exp_cnt[d]);
      chk($sformatf("line_time_%0d", d), line_time[d],
          ((d == 0) ? T_A * 11 : T_B * 10) + 1 + stalls[d]);
      done_cnt[d]++;
    end
  endtask

  task automatic start_line(input int d, input int y);
    int t;
    t = (d == 0) ? T_A : T_B;
    @(negedge clk);
    if (d == 0) begin
      bus_a.line_y = 10'(y); bus_a.line_start = 1'b1;
    end else begin
      bus_b.line_y = 10'(y); bus_b.line_start = 1'b1;
    end
    for (int n = 0; n < t; n++)
      for (int p = 0; p < 8; p++)
        if (d == 0) q_a.push_back(exp_px(4, y, n, p));
        else q_b.push_back(exp_px(1, y, n, p));
    exp_cnt[d]    = t * 8;
    pix_cnt[d]    = 0;
    stalls[d]     = 0;
    prev_stall[d] = 1'b0;
    start_cyc[d]  = cyc + 1;
    @(negedge clk);
    if (d == 0) bus_a.line_start = 1'b0;
    else bus_b.line_start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int d0);
    int k;
    k = 0;
    while (done_cnt[d] == d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt[d] == d0) chk($sformatf("done_timeout_%0d", d), 0, 1);
  endtask

  task automatic run_line(input int d, input int y, input int dt);
    int d0;
    duty[d] = dt;
    d0 = done_cnt[d];
    start_line(d, y);
    wait_done(d, d0);
  endtask

  initial begin
    logic [7:0] bexp [8];
    int d0;
    bexp = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
    for (int i = 0; i < 2; i++) begin
      pix_cnt[i] = 0; stalls[i] = 0; done_cnt[i] = 0; start_cyc[i] = 0;
      line_time[i] = 0; exp_cnt[i] = 0; duty[i] = 0;
      prev_stall[i] = 1'b0; prev_data[i] = 8'h00;
    end
    bus_a.line_start = 1'b0; bus_a.line_y = 10'd0; bus_a.px_ready = 1'b1;
    bus_b.line_start = 1'b0; bus_b.line_y = 10'd0; bus_b.px_ready = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      mem[18'(i)]            = 16'($urandom);
      mem[18'(32'h10000 + i)] = 16'($urandom);
    end
    mem[18'h00000] = 16'h0005;
    mem[18'h00001] = 16'h0A05;
    mem[18'h00002] = 16'h2005;
    mem[18'h00080] = 16'h0003;
    mem[18'h10050] = 16'h0123;
    mem[18'h10051] = 16'h4567;
    mem[18'h10028] = 16'hC3A5;

    fork
      begin : stim
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", int'({bus_a.busy, bus_a.line_done, bus_a.px_valid, bus_a.ram_ce,
                                     bus_a.ram_oe, bus_a.ram_addr, bus_a.px_data}), 0);
        chk("reset_outputs_b", int'({bus_b.busy, bus_b.line_done, bus_b.px_valid, bus_b.ram_ce,
                                     bus_b.ram_oe, bus_b.ram_addr, bus_b.px_data}), 0);
        chk("ram_static_a", int'({bus_a.ram_we, bus_a.ram_lb, bus_a.ram_hb}), 3);
        reset = 1'b0;

        run_line(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("lit_tile0_px%0d", i), int'(got[0][i]), i);
          chk($sformatf("lit_pal5_px%0d", i), int'(got[0][8 + i]), 8'h50 + i);
`ifdef HFLIP_EN
          chk($sformatf("lit_flip_px%0d", i), int'(got[0][16 + i]), 7 - i);
`else
          chk($sformatf("lit_noflip_px%0d", i), int'(got[0][16 + i]), i);
`endif
        end
        chk("lit_line_pixels", pix_cnt[0], 320);
        chk("lit_line_time", line_time[0], 441);

        run_line(1, 0, 0);
        for (int i = 0; i < 8; i++)
          chk($sformatf("lit_bpp1_px%0d", i), int'(got[1][i]), int'(bexp[i]));

        duty[0] = 0;
        d0 = done_cnt[0];
        start_line(0, 17);
        chk("lit_map_addr_y17", int'(bus_a.ram_addr), 32'h00080);
        chk("busy_after_start", int'({bus_a.busy, bus_a.ram_ce, bus_a.ram_oe}), 7);
        @(negedge clk);
        chk("lit_pat_addr_y17", int'(bus_a.ram_addr), 32'h10032);
        wait_done(0, d0);

        for (int r = 0; r < 5; r++) run_line(0, int'($urandom_range(0, 1023)), 30);
        for (int r = 0; r < 4; r++) run_line(1, int'($urandom_range(0, 1023)), 30);

        // second line_start while busy must be ignored
        duty[0] = 30;
        d0 = done_cnt[0];
        start_line(0, int'($urandom_range(0, 1023)));
        repeat (40) @(negedge clk);
        bus_a.line_y = 10'd333; bus_a.line_start = 1'b1;
        @(negedge clk);
        bus_a.line_start = 1'b0;
        wait_done(0, d0);
        d0 = done_cnt[0];
        repeat (600) @(posedge clk);
        chk("single_line_done", done_cnt[0] - d0, 0);

        // reset during the pattern fetch aborts the line
        duty[0] = 0;
        d0 = done_cnt[0];
        start_line(0, 9);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_outputs_zero", int'({bus_a.busy, bus_a.line_done, bus_a.px_valid, bus_a.ram_ce,
                                        bus_a.ram_oe, bus_a.ram_addr, bus_a.px_data}), 0);
        q_a.delete();
        prev_stall[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        chk("abort_no_done", done_cnt[0] - d0, 0);
        run_line(0, 9, 30);
        fin = 1'b1;
      end
      begin : monitor
        while (!fin) begin
          @(negedge clk);
          mon(0, bus_a.px_valid, bus_a.px_ready, bus_a.px_data, bus_a.line_done, bus_a.busy);
          mon(1, bus_b.px_valid, bus_b.px_ready, bus_b.px_data, bus_b.line_done, bus_b.busy);
        end
      end
      begin : ready_drv
        while (!fin) begin
          @(posedge clk);
          #1;
          bus_a.px_ready = (duty[0] == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(duty[0]));
          bus_b.px_ready = (duty[1] == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(duty[1]));
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_line_fetcher.md
Name: tile_line_fetcher

Overview:
Parametrised successor to the single-mode background fetcher. Once per active line it reads TILES_PER_LINE character entries from SRAM, fetches each tile's pattern row and expands it into per-pixel palette indices. Pixels are pushed through a valid/ready stream into the external pixel-domain FIFO. It sits in the clk domain between the SRAM port and that FIFO, and supports 1/2/4 bits per pixel and back-pressure, which the previous block lacked.

Parameters:
TILES_PER_LINE, 40, character entries fetched per line (1..255)
MAP_W, 64, map row pitch in words; must be a power of two
MAP_BASE, 18'h00000, SRAM word address of the character map
TILE_BASE, 18'h10000, SRAM word address of tile pattern data
BPP, 4, bits per pixel (1, 2 or 4); tile width fixed at 8 pixels, height at 8 rows

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
line_start  in  1  one-cycle pulse requesting a line fetch
line_y  in  10  display line to fetch; sampled with line_start
busy  out  1  high from accepted line_start until line_done
line_done  out  1  one-cycle pulse after the last pixel is accepted
px_data  out  8  {palette[3:0], index[3:0]}; index zero-extended for BPP<4
px_valid  out  1  px_data is valid
px_ready  in  1  downstream can accept (e.g. ~fifo_full)
ram_addr  out  18  SRAM word address
ram_din  in  16  SRAM read data, valid the cycle after ram_addr changes
ram_ce, ram_oe  out  1 each  SRAM enables; high only while fetching
ram_we, ram_lb, ram_hb  out  1 each  ram_we constant 0; ram_lb and ram_hb constant 1

Behaviour:
- Reset: state IDLE; busy, line_done, px_valid, ram_ce and ram_oe are 0; ram_addr and px_data are 0. Reset mid-line aborts immediately; no line_done is issued.
- WPR = BPP/2 pattern words per tile row (BPP=1 gives 1 word: the row's 8 pixels occupy bits [7:0] and the high byte is ignored).
- Map address = MAP_BASE + (line_y[9:3] * MAP_W) + tile_n, mod 2^18.
- Pattern address = TILE_BASE + tile_id*8*WPR + line_y[2:0]*WPR + w, mod 2^18.
- Character entry: [8:0] tile_id, [12:9] palette, [13] hflip, [15:14] ignored.
- States:
  - IDLE: on line_start, latch line_y, drive the map address for tile 0, assert ce/oe and busy, go to CHAR. A line_start while busy is ignored.
  - CHAR: capture the entry from ram_din, drive pattern word 0, go to PAT.
  - PAT: capture word w and drive word w+1. After the last word, go to PUSH with the pixel counter at 0.
  - PUSH: px_valid=1. Pixel 0 is the most-significant BPP field of word 0, proceeding MSB-first across words. The counter advances only on px_valid & px_ready; px_data holds stable while stalled.
  - On the accepted pixel 7: if tile_n < TILES_PER_LINE-1, drive the next map address and go to CHAR. Otherwise deassert ce/oe, pulse line_done, drop busy on the same edge, and go to IDLE.
- Per-tile overhead: 1+WPR cycles. Minimum line time: TILES_PER_LINE*(9+WPR)+1 cycles.
- tile_n and the pixel counter wrap only via reset or a new line; no pixel is ever dropped or duplicated under any px_ready pattern.

Optional Feature:
HFLIP_EN — defined: when entry bit 13 is 1, the tile row is emitted in reverse pixel order (pixel 7 first). Undefined: bit 13 is ignored and rows are always emitted in normal order.

Decomposition:
- Package tile_fetch_pkg: state enum (IDLE, CHAR, PAT, PUSH), entry field bit positions, TILE_W=8 and TILE_H=8 constants, and a WPR function of BPP.
- Sub-module tile_row_shifter: loads WPR words, extracts pixel k with optional flip, and outputs the index.

Test Plan:
- BPP=4, map entry 0x0005 at MAP_BASE, tile 5 row 0 = 0x0123,0x4567, line_y=0, px_ready=1 -> px_data 0x00..0x07 on 8 consecutive valid cycles.
- Entry 0x0A05 (palette 5) -> px_data 0x50..0x57; TILES_PER_LINE=40 -> exactly 320 pixels, line_done once, busy low the same cycle.
- px_ready toggling 1-0 with a random 30% duty -> identical 320-pixel sequence, px_data stable on every stalled cycle, line time extended by the stall count.
- line_y=17 -> first map read at MAP_BASE+128, pattern row 1; BPP=1 with word 0x00A5 -> indices 1,0,1,0,0,1,0,1.
- HFLIP_EN defined, entry 0x2005 -> pixels 7..0; without the macro -> 0..7.
- Reset asserted during PAT -> all outputs 0 asynchronously; the next line_start fetches cleanly from tile 0. A line_start while busy -> ignored, exactly one line_done.
